// File: rtl/pwr_est_pkg.sv
// Shared types for the power-estimation enable sequencer.
// Mode encodings, FSM states and default harness width.
package pwr_est_pkg;

    localparam int NUM_MODULES_DEF = 32;
    localparam int STEP_W          = 6;

    typedef enum logic [1:0] {
        MODE_RAMP      = 2'd0,
        MODE_WALK      = 2'd1,
        MODE_ALL       = 2'd2,
        MODE_RAMP_LOOP = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/pwr_pattern_gen.sv
// Combinational enable pattern for a given mode and step index,
// plus a flag marking the final step of that mode's sequence.
module pwr_pattern_gen
    import pwr_est_pkg::*;
#(
    parameter int NUM_MODULES = NUM_MODULES_DEF
) (
    input  mode_e                   mode,
    input  logic [STEP_W-1:0]       step,
    output logic [NUM_MODULES-1:0]  pattern,
    output logic                    last_step
);

    always_comb begin
        pattern   = '0;
        last_step = 1'b0;
        unique case (mode)
            MODE_RAMP, MODE_RAMP_LOOP: begin
                for (int i = 0; i < NUM_MODULES; i++) begin
                    pattern[i] = (int'(step) > i);
                end
                last_step = (int'(step) >= NUM_MODULES);
            end
            MODE_WALK: begin
                // step 0 is the all-off baseline
                for (int i = 0; i < NUM_MODULES; i++) begin
                    pattern[i] = (int'(step) == i + 1);
                end
                last_step = (int'(step) >= NUM_MODULES);
            end
            MODE_ALL: begin
                pattern   = (step != '0) ? '1 : '0;
                last_step = (step != '0);
            end
        endcase
    end

endmodule

// File: rtl/pwr_en_sequencer.sv
// Steps the harness power-enable vector through scripted patterns,
// each held for a settle window followed by a measurement window.
module pwr_en_sequencer
    import pwr_est_pkg::*;
#(
    parameter int NUM_MODULES  = NUM_MODULES_DEF,
    parameter int GUARD_CYCLES = 10000000,
    parameter int CNT_W        = 32
) (
    input  logic                    clk100m,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    stop,
    input  logic [1:0]              mode,
    input  logic [CNT_W-1:0]        dwell_cycles,
    output logic [NUM_MODULES-1:0]  pwr_en_out,
    output logic [STEP_W-1:0]       step_idx,
    output logic                    step_strobe,
    output logic                    meas_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int GL = (GUARD_CYCLES > 1) ? GUARD_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GL);

    state_e                  state_q, state_d;
    mode_e                   mode_q, mode_d;
    logic [CNT_W-1:0]        dwell_q, dwell_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [STEP_W-1:0]       step_idx_q, step_idx_d;
    logic                    last_q, last_d;
    logic [NUM_MODULES-1:0]  pwr_en_q, pwr_en_d;
    logic                    strobe_q, strobe_d;
    logic                    meas_q, meas_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [NUM_MODULES-1:0]  pattern;
    logic [CNT_W-1:0]        cnt_inc;
    logic [CNT_W-1:0]        dwell_last;

    // pattern and last flag are computed for the step being entered
    pwr_pattern_gen #(
        .NUM_MODULES (NUM_MODULES)
    ) u_pat (
        .mode      (mode_d),
        .step      (step_idx_d),
        .pattern   (pattern),
        .last_step (last_d)
    );

    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - 1'b1;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        dwell_d    = dwell_q;
        cnt_d      = cnt_q;
        step_idx_d = step_idx_q;
        strobe_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                step_idx_d = '0;
                if (start && !stop) begin
                    state_d = ST_SETTLE;
                    mode_d  = mode_e'(mode);
                    dwell_d = dwell_cycles;
                    cnt_d   = '0;
                    strobe_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q >= GUARD_LAST) begin
                    state_d = ST_MEASURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_MEASURE: begin
                if (cnt_q >= dwell_last) begin
                    cnt_d = '0;
                    if (!last_q) begin
                        state_d    = ST_SETTLE;
                        step_idx_d = step_idx_q + 1'b1;
                        strobe_d   = 1'b1;
                    end else if (mode_q == MODE_RAMP_LOOP) begin
                        state_d    = ST_SETTLE;
                        step_idx_d = '0;
                        strobe_d   = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                step_idx_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (stop && state_q != ST_IDLE) begin
            state_d    = ST_IDLE;
            step_idx_d = '0;
            cnt_d      = '0;
            strobe_d   = 1'b0;
        end

        busy_d   = (state_d != ST_IDLE);
        meas_d   = (state_d == ST_MEASURE);
        done_d   = (state_d == ST_DONE);
        pwr_en_d = (state_d == ST_SETTLE || state_d == ST_MEASURE)
                 ? pattern : '0;
    end

    always_ff @(posedge clk100m) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_RAMP;
            dwell_q    <= '0;
            cnt_q      <= '0;
            step_idx_q <= '0;
            last_q     <= 1'b0;
            pwr_en_q   <= '0;
            strobe_q   <= 1'b0;
            meas_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            dwell_q    <= dwell_d;
            cnt_q      <= cnt_d;
            step_idx_q <= step_idx_d;
            last_q     <= last_d;
            pwr_en_q   <= pwr_en_d;
            strobe_q   <= strobe_d;
            meas_q     <= meas_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign pwr_en_out  = pwr_en_q;
    assign step_idx    = step_idx_q;
    assign step_strobe = strobe_q;
    assign meas_valid  = meas_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pwr_en_sequencer.sv
// Directed table-driven bench for pwr_en_sequencer (4 modules, guard 2).
// Each cycle the output bundle is compared against a hand-built trace.
module tb_pwr_en_sequencer;

    logic        clk100m = 1'b0;
    logic        rstn    = 1'b0;
    logic        start   = 1'b0;
    logic        stop    = 1'b0;
    logic [1:0]  mode_i  = 2'd0;
    logic [31:0] dwell_i = 32'd0;
    logic [3:0]  pwr_en_out;
    logic [5:0]  step_idx;
    logic        step_strobe;
    logic        meas_valid;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    always #5 clk100m = ~clk100m;

    pwr_en_sequencer #(
        .NUM_MODULES  (4),
        .GUARD_CYCLES (2),
        .CNT_W        (32)
    ) dut (
        .clk100m      (clk100m),
        .rstn         (rstn),
        .start        (start),
        .stop         (stop),
        .mode         (mode_i),
        .dwell_cycles (dwell_i),
        .pwr_en_out   (pwr_en_out),
        .step_idx     (step_idx),
        .step_strobe  (step_strobe),
        .meas_valid   (meas_valid),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        logic [1:0]      mode;
        logic [31:0]     dwell;
        logic [4:0][3:0] pats;
        int              done_at;
        int              busy_start;
    } vec_t;

    vec_t vecs[4];

    // bundle: {pwr_en[13:10], step[9:4], strobe, meas, busy, done}
    localparam logic [13:0] M_ALL  = 14'h3fff;
    localparam logic [13:0] M_NOST = 14'h3c0f;

    function automatic logic [13:0] obs();
        return {pwr_en_out, step_idx, step_strobe, meas_valid, busy, done};
    endfunction

    function automatic logic [13:0] bundle(logic [3:0] p, int k,
                                           logic s, logic m,
                                           logic b, logic d);
        return {p, 6'(k), s, m, b, d};
    endfunction

    task automatic chk(string name, logic [13:0] act,
                       logic [13:0] exp, logic [13:0] mask);
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s: got %h expected %h (mask %h)",
                     name, act & mask, exp & mask, mask);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int per, k, off;
        logic [13:0] exp;
        logic [13:0] msk;
        per = 2 + ((v.dwell == 0) ? 1 : int'(v.dwell));
        @(negedge clk100m);
        mode_i = v.mode; dwell_i = v.dwell; start = 1'b1;
        @(negedge clk100m);
        start = 1'b0;
        for (int c = 1; c <= v.done_at + 1; c++) begin
            if (c < v.done_at) begin
                k   = (c - 1) / per;
                off = (c - 1) % per;
                exp = bundle(v.pats[k], k, off == 0, off >= 2, 1'b1, 1'b0);
                msk = M_ALL;
            end else if (c == v.done_at) begin
                exp = bundle(4'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
                msk = M_NOST;
            end else begin
                exp = '0;
                msk = M_NOST;
            end
            chk($sformatf("vec%0d cyc%0d", id, c), obs(), exp, msk);
            if (v.busy_start != 0 && c == v.busy_start) begin
                start = 1'b1; mode_i = 2'd2; dwell_i = 32'd9;
            end
            if (v.busy_start != 0 && c == v.busy_start + 1) start = 1'b0;
            @(negedge clk100m);
        end
    endtask

    logic [4:0][3:0] ramp_p;

    initial begin
        ramp_p  = {4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        // done_at = steps * (guard + max(dwell,1)) + 1
        vecs[0] = '{2'd0, 32'd3, ramp_p, 26, 0};
        vecs[1] = '{2'd1, 32'd1,
                    {4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000}, 16, 0};
        vecs[2] = '{2'd2, 32'd0,
                    {4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000}, 7, 0};
        vecs[3] = '{2'd1, 32'd1,
                    {4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000}, 16, 5};

        repeat (3) @(negedge clk100m);
        chk("reset", obs(), '0, M_ALL);
        rstn = 1'b1;
        @(negedge clk100m);
        chk("idle", obs(), '0, M_ALL);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1; mode_i = 2'd0; dwell_i = 32'd1;
        @(negedge clk100m);
        start = 1'b0; stop = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("startstop c%0d", c), obs(), '0, M_ALL);
            @(negedge clk100m);
        end

        // ramp-loop: two full passes, stop during step 3 measure
        mode_i = 2'd3; dwell_i = 32'd2; start = 1'b1;
        @(negedge clk100m);
        start = 1'b0;
        for (int c = 1; c <= 55; c++) begin
            int k, off;
            k   = ((c - 1) / 4) % 5;
            off = (c - 1) % 4;
            chk($sformatf("loop cyc%0d", c), obs(),
                bundle(ramp_p[k], k, off == 0, off >= 2, 1'b1, 1'b0), M_ALL);
            if (c == 21)
                chk("wrap", {8'b0, step_idx, step_strobe},
                    {8'b0, 6'd0, 1'b1}, M_ALL);
            if (c == 55) stop = 1'b1;
            @(negedge clk100m);
        end
        stop = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("after stop c%0d", c), obs(), '0, M_ALL);
            @(negedge clk100m);
        end

        // synchronous reset in the middle of a measure window
        mode_i = 2'd0; dwell_i = 32'd3; start = 1'b1;
        @(negedge clk100m);
        start = 1'b0;
        repeat (3) @(negedge clk100m);
        chk("pre-rst meas", {13'b0, meas_valid}, 14'd1, M_ALL);
        rstn = 1'b0;
        @(negedge clk100m);
        chk("mid rst", obs(), '0, M_ALL);
        rstn = 1'b1;
        run_vec(vecs[0], 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
